regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; index width is 5.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports iss_valid  input  1; iss_rd, iss_rs1, iss_rs2  input  5 each; decode-stage issue request.
REQ-007 SHALL have port iss_stall  output  1  hazard stall to decode (combinational).
REQ-008 SHALL have ports a_valid  input  1; a_rd  input  5; a_data  input  XLEN; a_ready  output  1; ALU writeback channel.
REQ-009 SHALL have ports b_valid  input  1; b_rd  input  5; b_data  input  XLEN; b_ready  output  1; load-unit writeback channel.
REQ-010 SHALL have ports wr_en  output  1; wr_addr  output  5; wr_data  output  XLEN; registered register-file write port.
REQ-011 SHALL have port busy_o  output  NREG  scoreboard, bit i = register i has a pending write.
REQ-012 SHALL have ports err_o  output  1 (sticky) and wb_cnt_o  output  32 (completed-writeback count).

Function
REQ-013 SHALL assert iss_stall when iss_valid=1 and any of busy[iss_rs1], busy[iss_rs2], busy[iss_rd] is 1; busy[0] is always 0.
REQ-014 SHALL set busy[iss_rd] at the clock edge when iss_valid=1, iss_stall=0 and iss_rd!=0.
REQ-015 SHALL clear busy[rd] at the clock edge on which a writeback handshake (valid&&ready) for rd completes.
REQ-016 SHALL not bypass: a clear in cycle N does not lower iss_stall until cycle N+1.
REQ-017 SHALL arbitrate with a two-state FSM PRI_A/PRI_B: single valid requester is granted; both valid grants the prioritised one.
REQ-018 SHALL move FSM to the state favouring the other requester after every grant; no grant leaves state unchanged.
REQ-019 SHALL drive a_ready/b_ready combinationally as the grant; at most one is 1 per cycle.
REQ-020 SHALL require requesters to hold valid, rd and data stable until ready; a granted requester may present a new request the next cycle.
REQ-021 SHALL register the granted rd/data onto wr_addr/wr_data with wr_en=1 exactly one cycle after the handshake; wr_en=0 otherwise.
REQ-022 SHALL accept a writeback with rd=0 (ready given, wb_cnt_o incremented) but keep wr_en=0.
REQ-023 SHALL set err_o on a handshake whose rd!=0 is not busy; write still performed; err_o clears only on reset.
REQ-024 SHALL increment wb_cnt_o by 1 per handshake, wrapping 0xFFFFFFFF -> 0.
REQ-025 SHALL guarantee a continuously valid requester is granted within 2 cycles.

Reset
REQ-026 SHALL, while reset=1, force busy_o=0, wr_en=0, wr_addr=0, wr_data=0, err_o=0, wb_cnt_o=0, FSM=PRI_A, independent of clk.
REQ-027 SHALL drop any in-flight registered write on reset (no wr_en pulse after deassertion without a new handshake).
REQ-028 SHALL, during reset, drive a_ready=b_ready=0 and ignore issue requests.

Structure
REQ-029 SHALL take XLEN, NREG, the 5-bit register-index typedef and the PRI_A/PRI_B state encoding from shared package regfile_pkg.
REQ-030 SHALL implement arbitration in one sub-module rr_arb2 (2-requester round-robin, state + grant); scoreboard, write register and counter remain in regfile_wb_ctrl.

Verification
REQ-031 SHALL cover: issue rd=5 -> busy_o[5]=1 next cycle; issue with rs1=5 -> iss_stall=1 until cycle after writeback rd=5 handshake.
REQ-032 SHALL cover: a_valid and b_valid held 4 cycles from reset -> grants A,B,A,B; wr_en pulses carry matching rd/data one cycle later.
REQ-033 SHALL cover: b_valid rd=0 data=0xDEADBEEF -> b_ready=1, wr_en stays 0, wb_cnt_o +1, busy_o unchanged.
REQ-034 SHALL cover: writeback rd=7 with busy_o[7]=0 -> err_o=1 and stays 1 until reset; wr_en=1, wr_addr=7.
REQ-035 SHALL cover: reset asserted mid-clock with handshake pending -> all outputs zero immediately, no wr_en after release; wb_cnt_o preloaded 0xFFFFFFFF wraps to 0 on next handshake.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, register-index type and arbiter state encoding for the
// register-file writeback controller.
package regfile_pkg;
   localparam int XLEN      = 32;
   localparam int NREG      = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } arb_state_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, writeback and register-file write signals of the writeback controller.
// The master side drives requests; the slave side is the controller.
interface regfile_wb_ctrl_if
   import regfile_pkg::*;
#(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int NREG = regfile_pkg::NREG
);
   logic             iss_valid;
   reg_idx_t         iss_rd;
   reg_idx_t         iss_rs1;
   reg_idx_t         iss_rs2;
   logic             iss_stall;

   logic             a_valid;
   reg_idx_t         a_rd;
   logic [XLEN-1:0]  a_data;
   logic             a_ready;

   logic             b_valid;
   reg_idx_t         b_rd;
   logic [XLEN-1:0]  b_data;
   logic             b_ready;

   logic             wr_en;
   reg_idx_t         wr_addr;
   logic [XLEN-1:0]  wr_data;
   logic [NREG-1:0]  busy_o;
   logic             err_o;
   logic [31:0]      wb_cnt_o;

   modport master (
      output iss_valid, iss_rd, iss_rs1, iss_rs2,
      output a_valid, a_rd, a_data,
      output b_valid, b_rd, b_data,
      input  iss_stall, a_ready, b_ready,
      input  wr_en, wr_addr, wr_data, busy_o, err_o, wb_cnt_o
   );

   modport slave (
      input  iss_valid, iss_rd, iss_rs1, iss_rs2,
      input  a_valid, a_rd, a_data,
      input  b_valid, b_rd, b_data,
      output iss_stall, a_ready, b_ready,
      output wr_en, wr_addr, wr_data, busy_o, err_o, wb_cnt_o
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, priority flips to the
// other requester after every grant.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);
   arb_state_e state_q;

   // Grants are held low while reset is asserted so nothing can handshake.
   assign gnt_a_o = !reset && req_a_i && (state_q == PRI_A || !req_b_i);
   assign gnt_b_o = !reset && req_b_i && (state_q == PRI_B || !req_a_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PRI_A;
      end else if (gnt_a_o) begin
         state_q <= PRI_B;
      end else if (gnt_b_o) begin
         state_q <= PRI_A;
      end
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: busy scoreboard with issue stall,
// arbitrated ALU/load writeback into a registered write port, error and count.
module regfile_wb_ctrl
   import regfile_pkg::*;
#(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int NREG = regfile_pkg::NREG
) (
   input  logic               clk,
   input  logic               reset,
   regfile_wb_ctrl_if.slave   bus
);
   logic [NREG-1:0] busy_q, busy_d;
   logic            wr_en_q;
   reg_idx_t        wr_addr_q;
   logic [XLEN-1:0] wr_data_q;
   logic            err_q, err_d;
   logic [31:0]     wb_cnt_q, wb_cnt_d;

   logic            gnt_a, gnt_b, hs;
   reg_idx_t        hs_rd;
   logic [XLEN-1:0] hs_data;
   logic            iss_stall;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_a_i (bus.a_valid),
      .req_b_i (bus.b_valid),
      .gnt_a_o (gnt_a),
      .gnt_b_o (gnt_b)
   );

   assign hs      = gnt_a | gnt_b;
   assign hs_rd   = gnt_a ? bus.a_rd   : bus.b_rd;
   assign hs_data = gnt_a ? bus.a_data : bus.b_data;

   // Stall looks only at registered busy bits, so a clear is seen a cycle later.
   assign iss_stall = bus.iss_valid &&
                      (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] || busy_q[bus.iss_rd]);

   always_comb begin
      busy_d = busy_q;
      if (hs) begin
         busy_d[hs_rd] = 1'b0;
      end
      if (bus.iss_valid && !iss_stall && bus.iss_rd != '0) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign err_d    = err_q || (hs && hs_rd != '0 && !busy_q[hs_rd]);
   assign wb_cnt_d = hs ? wb_cnt_q + 32'd1 : wb_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         wb_cnt_q  <= '0;
      end else begin
         busy_q   <= busy_d;
         err_q    <= err_d;
         wb_cnt_q <= wb_cnt_d;
         // Writes to r0 are acknowledged and counted but never reach the file.
         wr_en_q  <= hs && hs_rd != '0;
         if (hs) begin
            wr_addr_q <= hs_rd;
            wr_data_q <= hs_data;
         end
      end
   end

   assign bus.iss_stall = iss_stall;
   assign bus.a_ready   = gnt_a;
   assign bus.b_ready   = gnt_b;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy_o    = busy_q;
   assign bus.err_o     = err_q;
   assign bus.wb_cnt_o  = wb_cnt_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the scoreboard and arbiter.
module tb_regfile_wb_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_ctrl_if #(.XLEN(32), .NREG(32)) bus ();

   regfile_wb_ctrl #(.XLEN(32), .NREG(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        stall;
      logic        ar;
      logic        br;
      logic        wr_en;
      logic        err;
      logic [31:0] busy;
      logic [31:0] cnt;
   } rec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   rec_t recq[$];
   wr_t  wq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   bit          m_busy[32];
   bit          m_last_a;
   bit          m_err;
   logic [31:0] m_cnt;
   bit          m_pend;
   bit          m_ga, m_gb;

   rec_t        mon_r;
   wr_t         mon_w;

   logic        ap, bp;
   logic [4:0]  ard, brd;
   logic [31:0] adat, bdat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic logic [4:0] pick_rd();
      int q[$];
      for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) return 5'(q[$urandom_range(0, q.size() - 1)]);
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_last_a = 1'b0;
      m_err    = 1'b0;
      m_cnt    = '0;
      m_pend   = 1'b0;
      wq.delete();
   endtask

   task automatic drive_idle();
      bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
      bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},    bus.busy_o,   32'h0);
      chk({tag, "_wr_en"},   32'(bus.wr_en), 32'h0);
      chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'h0);
      chk({tag, "_wr_data"}, bus.wr_data,  32'h0);
      chk({tag, "_err"},     32'(bus.err_o), 32'h0);
      chk({tag, "_cnt"},     bus.wb_cnt_o, 32'h0);
      chk({tag, "_a_ready"}, 32'(bus.a_ready), 32'h0);
      chk({tag, "_b_ready"}, 32'(bus.b_ready), 32'h0);
   endtask

   // One clock cycle of stimulus; the expected outputs for it go to the scoreboard.
   task automatic step(input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
                       input logic [4:0] irs2,
                       input logic av, input logic [4:0] a_rd, input logic [31:0] a_dat,
                       input logic bv, input logic [4:0] b_rd, input logic [31:0] b_dat);
      rec_t        r;
      wr_t         w;
      logic        hs;
      logic [4:0]  hrd;
      logic [31:0] hdat;
      @(posedge clk);
      #1;
      bus.iss_valid = iv; bus.iss_rd = ird; bus.iss_rs1 = irs1; bus.iss_rs2 = irs2;
      bus.a_valid = av; bus.a_rd = a_rd; bus.a_data = a_dat;
      bus.b_valid = bv; bus.b_rd = b_rd; bus.b_data = b_dat;
      r.stall = iv && (m_busy[irs1] || m_busy[irs2] || m_busy[ird]);
      m_ga    = av && (!bv || !m_last_a);
      m_gb    = bv && !m_ga;
      r.ar    = m_ga;
      r.br    = m_gb;
      r.wr_en = m_pend;
      r.err   = m_err;
      r.cnt   = m_cnt;
      r.busy  = busy_vec();
      recq.push_back(r);
      hs   = m_ga || m_gb;
      hrd  = m_ga ? a_rd : b_rd;
      hdat = m_ga ? a_dat : b_dat;
      m_pend = 1'b0;
      if (hs) begin
         m_cnt    = m_cnt + 32'd1;
         m_last_a = m_ga;
         if (hrd != 5'd0) begin
            if (!m_busy[hrd]) m_err = 1'b1;
            m_busy[hrd] = 1'b0;
            m_pend = 1'b1;
            w.addr = hrd;
            w.data = hdat;
            wq.push_back(w);
         end
      end
      if (iv && !r.stall && ird != 5'd0) m_busy[ird] = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic plain_reset();
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      #1;
      check_reset_outputs("rst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compares every scheduled cycle and pops a write on each wr_en pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (recq.size() != 0) begin
            mon_r = recq.pop_front();
            chk("iss_stall", 32'(bus.iss_stall), 32'(mon_r.stall));
            chk("a_ready",   32'(bus.a_ready),   32'(mon_r.ar));
            chk("b_ready",   32'(bus.b_ready),   32'(mon_r.br));
            chk("wr_en",     32'(bus.wr_en),     32'(mon_r.wr_en));
            chk("err_o",     32'(bus.err_o),     32'(mon_r.err));
            chk("busy_o",    bus.busy_o,         mon_r.busy);
            chk("wb_cnt_o",  bus.wb_cnt_o,       mon_r.cnt);
            if (bus.wr_en === 1'b1) begin
               if (wq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL wr_unexpected: got addr %h data %h expected no write",
                           bus.wr_addr, bus.wr_data);
               end else begin
                  mon_w = wq.pop_front();
                  chk("wr_addr", 32'(bus.wr_addr), 32'(mon_w.addr));
                  chk("wr_data", bus.wr_data, mon_w.data);
               end
            end
         end
      end
   end

   initial begin
      drive_idle();
      model_reset();
      #1 reset = 1'b1;
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Hazard on r5 holds the issue until the cycle after its writeback.
      step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
      step(1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
      step(1, 6, 5, 0, 1, 5, 32'h0000_0055, 0, 0, 0);
      step(1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // Both channels valid from a fresh reset alternate A,B,A,B.
      plain_reset();
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'hA000_0001, 1, 2, 32'hB000_0002);
      step(0, 0, 0, 0, 1, 3, 32'hA000_0003, 1, 2, 32'hB000_0002);
      step(0, 0, 0, 0, 1, 3, 32'hA000_0003, 1, 4, 32'hB000_0004);
      step(0, 0, 0, 0, 1, 0, 32'hA000_0000, 1, 4, 32'hB000_0004);
      step(0, 0, 0, 0, 1, 0, 32'hA000_0000, 0, 0, 0);
      idle(2);

      // r0 writeback is acknowledged and counted only.
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      idle(1);

      // Writeback to a non-busy register sets the sticky error.
      step(0, 0, 0, 0, 1, 7, 32'h0000_7777, 0, 0, 0);
      idle(4);

      // Asynchronous reset with a handshake pending.
      @(posedge clk);
      #1;
      bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h0909_0909;
      bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h1111_1111;
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("mid");
      model_reset();
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(3);

      // Counter wrap from an all-ones preload.
      @(negedge clk);
      #1 force dut.wb_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.wb_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      #1 chk("cnt_preload", bus.wb_cnt_o, 32'hFFFF_FFFF);
      step(0, 0, 0, 0, 1, 0, 32'h1234_5678, 0, 0, 0);
      idle(2);

      // Randomized traffic obeying the hold-until-ready protocol.
      plain_reset();
      ap = 1'b0; bp = 1'b0;
      ard = '0; brd = '0; adat = '0; bdat = '0;
      for (int i = 0; i < 800; i++) begin
         if (!ap && $urandom_range(0, 2) == 0) begin
            ap = 1'b1; ard = pick_rd(); adat = $urandom;
         end
         if (!bp && $urandom_range(0, 2) == 0) begin
            bp = 1'b1; brd = pick_rd(); bdat = $urandom;
         end
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
              5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
              ap, ard, adat, bp, brd, bdat);
         if (m_ga) ap = 1'b0;
         if (m_gb) bp = 1'b0;
      end
      idle(3);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(recq.size()), 32'd0);
      chk("writes_drained", 32'(wq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
